step_counter: RTL and testbench

STEP_COUNTER -- requirements
Module: step_counter

---
 rtl/step_counter.sv | 76 +++++++
 tb/tb_step_counter.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/step_counter.sv
// step_counter: registered up-counter with wrap, saturate or ping-pong behaviour,
// synchronous load and a one-cycle event pulse on wrap/saturation/turn.
module step_counter #(
    parameter int WIDTH    = 5,
    parameter int STEP     = 4,
    parameter int LIMIT    = 28,
    parameter int MODE     = 0,
    parameter int IDLE_CLR = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cycle,
    input  logic             ld,
    input  logic [WIDTH-1:0] ld_val,
    output logic [WIDTH-1:0] nctr,
    output logic             evt,
    output logic             dir
);
    localparam logic [WIDTH:0]   STEP_W = (WIDTH+1)'(STEP);
    localparam logic [WIDTH:0]   LIM_W  = (WIDTH+1)'(LIMIT);
    localparam logic [WIDTH-1:0] STEP_N = WIDTH'(STEP);
    localparam logic [WIDTH-1:0] LIM_N  = WIDTH'(LIMIT);

    logic [WIDTH-1:0] nctr_q, nctr_d;
    logic             evt_q, evt_d, dir_q, dir_d;
    logic [WIDTH:0]   up;
    logic [WIDTH-1:0] up_n, dn_n;
    logic             fits, low;

    // the extra sum bit keeps nctr+STEP from aliasing back under LIMIT
    assign up   = {1'b0, nctr_q} + STEP_W;
    assign fits = up <= LIM_W;
    assign up_n = up[WIDTH-1:0];
    assign dn_n = nctr_q - STEP_N;
    assign low  = nctr_q < STEP_N;

    always_comb begin
        nctr_d = nctr_q;
        dir_d  = dir_q;
        evt_d  = 1'b0;
        if (ld) begin
            nctr_d = ({1'b0, ld_val} > LIM_W) ? LIM_N : ld_val;
        end else if (cycle) begin
            if (MODE == 1) begin
                nctr_d = fits ? up_n : LIM_N;
                evt_d  = (nctr_d == LIM_N) && (nctr_q != LIM_N);
            end else if (MODE == 2) begin
                nctr_d = dir_q ? (fits ? up_n : dn_n) : (low ? up_n : dn_n);
                dir_d  = dir_q ? fits : low;
                evt_d  = dir_q ? !fits : low;
            end else begin
                nctr_d = fits ? up_n : '0;
                evt_d  = !fits;
            end
        end else if (IDLE_CLR != 0) begin
            nctr_d = '0;
            dir_d  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            nctr_q <= '0;
            evt_q  <= 1'b0;
            dir_q  <= 1'b1;
        end else begin
            nctr_q <= nctr_d;
            evt_q  <= evt_d;
            dir_q  <= dir_d;
        end
    end

    assign nctr = nctr_q;
    assign evt  = evt_q;
    assign dir  = dir_q;
endmodule

// File: tb/tb_step_counter.sv
// tb_step_counter: scoreboard bench over four step_counter variants
// (wrap, wrap with hold-on-idle, saturate, bounce) sharing one stimulus.
module tb_step_counter;
    typedef struct {
        int         k;
        logic [4:0] n;
        logic       e;
        logic       d;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       cycle = 1'b0;
    logic       ld = 1'b0;
    logic [4:0] ld_val = '0;
    logic [4:0] n_a, n_b, n_c, n_d;
    logic       e_a, e_b, e_c, e_d, d_a, d_b, d_c, d_d;
    logic [6:0] obs [4];
    exp_t       q[$];
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    step_counter u_a (.clk(clk), .reset(reset), .cycle(cycle), .ld(ld), .ld_val(ld_val),
                      .nctr(n_a), .evt(e_a), .dir(d_a));
    step_counter #(.IDLE_CLR(0)) u_b (.clk(clk), .reset(reset), .cycle(cycle), .ld(ld),
                      .ld_val(ld_val), .nctr(n_b), .evt(e_b), .dir(d_b));
    step_counter #(.MODE(1)) u_c (.clk(clk), .reset(reset), .cycle(cycle), .ld(ld),
                      .ld_val(ld_val), .nctr(n_c), .evt(e_c), .dir(d_c));
    step_counter #(.MODE(2)) u_d (.clk(clk), .reset(reset), .cycle(cycle), .ld(ld),
                      .ld_val(ld_val), .nctr(n_d), .evt(e_d), .dir(d_d));

    assign obs[0] = {n_a, e_a, d_a};
    assign obs[1] = {n_b, e_b, d_b};
    assign obs[2] = {n_c, e_c, d_c};
    assign obs[3] = {n_d, e_d, d_d};

    function automatic void push(int k, int n, bit e, bit d);
        exp_t x;
        x.k = k;
        x.n = 5'(n);
        x.e = e;
        x.d = d;
        q.push_back(x);
    endfunction

    task automatic drive(logic c, logic l, logic [4:0] v);
        @(negedge clk);
        cycle  = c;
        ld     = l;
        ld_val = v;
    endtask

    task automatic do_reset();
        @(negedge clk);
        cycle = 1'b0;
        ld = 1'b0;
        reset = 1'b0;
        #2 reset = 1'b1;
    endtask

    task automatic test_reset();
        exp_t e;
        cycle = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) push(k, 0, 0, 1);
        while (q.size() > 0) begin
            e = q.pop_front();
            checks++;
            if (obs[e.k] !== {e.n, e.e, e.d}) begin
                errors++;
                $display("FAIL reset dut%0d: got n=%0d evt=%0b dir=%0b, want n=%0d evt=%0b dir=%0b",
                         e.k, obs[e.k][6:2], obs[e.k][1], obs[e.k][0], e.n, e.e, e.d);
            end
        end
        @(negedge clk);
        cycle = 1'b0;
        reset = 1'b1;
    endtask

    task automatic test_wrap();
        exp_t e;
        int wn[10] = '{4, 8, 12, 16, 20, 24, 28, 0, 4, 8};
        do_reset();
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 1'b0, 5'd0);
            push(0, wn[i], i == 7, 1);
            @(posedge clk);
            #1;
            while (q.size() > 0) begin
                e = q.pop_front();
                checks++;
                if (obs[e.k] !== {e.n, e.e, e.d}) begin
                    errors++;
                    $display("FAIL wrap dut%0d step%0d: got n=%0d evt=%0b dir=%0b, want n=%0d evt=%0b dir=%0b",
                             e.k, i, obs[e.k][6:2], obs[e.k][1], obs[e.k][0], e.n, e.e, e.d);
                end
            end
        end
    endtask

    task automatic test_idle();
        exp_t e;
        do_reset();
        for (int i = 0; i < 7; i++) begin
            drive(i < 4, 1'b0, 5'd0);
            push(0, i < 4 ? 4 * (i + 1) : 0, 0, 1);
            push(1, i < 4 ? 4 * (i + 1) : 16, 0, 1);
            @(posedge clk);
            #1;
            while (q.size() > 0) begin
                e = q.pop_front();
                checks++;
                if (obs[e.k] !== {e.n, e.e, e.d}) begin
                    errors++;
                    $display("FAIL idle dut%0d step%0d: got n=%0d evt=%0b dir=%0b, want n=%0d evt=%0b dir=%0b",
                             e.k, i, obs[e.k][6:2], obs[e.k][1], obs[e.k][0], e.n, e.e, e.d);
                end
            end
        end
    endtask

    task automatic test_saturate();
        exp_t e;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 1'b0, 5'd0);
            push(2, i < 7 ? 4 * (i + 1) : 28, i == 6, 1);
            @(posedge clk);
            #1;
            while (q.size() > 0) begin
                e = q.pop_front();
                checks++;
                if (obs[e.k] !== {e.n, e.e, e.d}) begin
                    errors++;
                    $display("FAIL saturate step%0d: got n=%0d evt=%0b dir=%0b, want n=%0d evt=%0b dir=%0b",
                             i, obs[e.k][6:2], obs[e.k][1], obs[e.k][0], e.n, e.e, e.d);
                end
            end
        end
    endtask

    task automatic test_bounce();
        exp_t e;
        int bn[16] = '{4, 8, 12, 16, 20, 24, 28, 24, 20, 16, 12, 8, 4, 0, 4, 8};
        do_reset();
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 1'b0, 5'd0);
            push(3, bn[i], i == 7 || i == 14, i < 7 || i >= 14);
            @(posedge clk);
            #1;
            while (q.size() > 0) begin
                e = q.pop_front();
                checks++;
                if (obs[e.k] !== {e.n, e.e, e.d}) begin
                    errors++;
                    $display("FAIL bounce step%0d: got n=%0d evt=%0b dir=%0b, want n=%0d evt=%0b dir=%0b",
                             i, obs[e.k][6:2], obs[e.k][1], obs[e.k][0], e.n, e.e, e.d);
                end
            end
        end
        // descending: load keeps dir, next count goes down, idle restores up
        do_reset();
        for (int i = 0; i < 12; i++) begin
            if (i < 9) begin
                drive(1'b1, 1'b0, 5'd0);
                push(3, bn[i], i == 7, i < 7);
            end else if (i == 9) begin
                drive(1'b1, 1'b1, 5'd31);
                push(3, 28, 0, 0);
            end else if (i == 10) begin
                drive(1'b1, 1'b0, 5'd0);
                push(3, 24, 0, 0);
            end else begin
                drive(1'b0, 1'b0, 5'd0);
                push(3, 0, 0, 1);
            end
            @(posedge clk);
            #1;
            while (q.size() > 0) begin
                e = q.pop_front();
                checks++;
                if (obs[e.k] !== {e.n, e.e, e.d}) begin
                    errors++;
                    $display("FAIL bounce_ld step%0d: got n=%0d evt=%0b dir=%0b, want n=%0d evt=%0b dir=%0b",
                             i, obs[e.k][6:2], obs[e.k][1], obs[e.k][0], e.n, e.e, e.d);
                end
            end
        end
    endtask

    task automatic test_load();
        exp_t e;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            if (i == 0) begin
                drive(1'b1, 1'b1, 5'd31);
                push(0, 28, 0, 1);
                push(2, 28, 0, 1);
            end else if (i == 1) begin
                drive(1'b1, 1'b1, 5'd6);
                push(0, 6, 0, 1);
                push(2, 6, 0, 1);
            end else begin
                drive(1'b1, 1'b0, 5'd0);
                push(0, i < 7 ? 6 + 4 * (i - 1) : 0, i == 7, 1);
                push(2, i < 7 ? 6 + 4 * (i - 1) : 28, i == 7, 1);
            end
            @(posedge clk);
            #1;
            while (q.size() > 0) begin
                e = q.pop_front();
                checks++;
                if (obs[e.k] !== {e.n, e.e, e.d}) begin
                    errors++;
                    $display("FAIL load dut%0d step%0d: got n=%0d evt=%0b dir=%0b, want n=%0d evt=%0b dir=%0b",
                             e.k, i, obs[e.k][6:2], obs[e.k][1], obs[e.k][0], e.n, e.e, e.d);
                end
            end
        end
    endtask

    task automatic test_async_reset();
        exp_t e;
        do_reset();
        repeat (8) drive(1'b1, 1'b0, 5'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        ld = 1'b1;
        ld_val = 5'd9;
        reset = 1'b0;
        #1;
        for (int k = 0; k < 4; k++) push(k, 0, 0, 1);
        while (q.size() > 0) begin
            e = q.pop_front();
            checks++;
            if (obs[e.k] !== {e.n, e.e, e.d}) begin
                errors++;
                $display("FAIL async_reset dut%0d: got n=%0d evt=%0b dir=%0b, want n=%0d evt=%0b dir=%0b",
                         e.k, obs[e.k][6:2], obs[e.k][1], obs[e.k][0], e.n, e.e, e.d);
            end
        end
        #1;
        ld = 1'b0;
        reset = 1'b1;
        for (int k = 0; k < 4; k++) push(k, 4, 0, 1);
        @(posedge clk);
        #1;
        while (q.size() > 0) begin
            e = q.pop_front();
            checks++;
            if (obs[e.k] !== {e.n, e.e, e.d}) begin
                errors++;
                $display("FAIL resume dut%0d: got n=%0d evt=%0b dir=%0b, want n=%0d evt=%0b dir=%0b",
                         e.k, obs[e.k][6:2], obs[e.k][1], obs[e.k][0], e.n, e.e, e.d);
            end
        end
    endtask

    initial begin
        #3;
        test_reset();
        test_wrap();
        test_idle();
        test_saturate();
        test_bounce();
        test_load();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
